interfaz_rx: RTL and testbench
==============================

# interfaz_rx

Receive-side command assembler between the UART receiver and the ALU. Collects three consecutive bytes from the receiver (operand A, operand B, opcode), then presents them to the ALU as one complete command with a single-cycle valid strobe. Mirror of the transmit-side interface, which returns the ALU result to the UART transmitter.

## Interface
- NB_DATA, 8, width of a received byte and of each ALU operand
- NB_OP, 6, ALU opcode width; NB_OP <= NB_DATA
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  reset, synchronous, active-low
- i_data  input  NB_DATA  byte from UART receiver, valid when i_done_rx=1
- i_done_rx  input  1  receiver byte-ready strobe; each cycle sampled high counts as one byte
- o_dato_a  output  NB_DATA  operand A of last complete command
- o_dato_b  output  NB_DATA  operand B of last complete command
- o_opcode  output  NB_OP  opcode of last complete command
- o_valid  output  1  one-cycle strobe to ALU: new command on outputs

## Operation
- FSM states: RX_A, RX_B, RX_OP, VALID; reset state RX_A.
- RX_A: on i_done_rx, i_data -> shadow_a; next RX_B. Otherwise hold.
- RX_B: on i_done_rx, i_data -> shadow_b; next RX_OP. Otherwise hold.
- RX_OP: on i_done_rx, o_dato_a <= shadow_a, o_dato_b <= shadow_b, o_opcode <= i_data[NB_OP-1:0] (upper NB_DATA-NB_OP bits discarded), all in the same edge; next VALID. Otherwise hold.
- VALID: lasts exactly one cycle. If i_done_rx=1 in this cycle, i_data -> shadow_a and next RX_B (byte not lost); else next RX_A.
- o_valid = (state==VALID), decoded from the state register, no combinational path from inputs.
- Outputs o_dato_a/o_dato_b/o_opcode change only on the RX_OP completion edge; they hold the previous command while a new one is being assembled (ALU never sees a half-updated command).
- No handshake back from ALU; a new command may overwrite outputs as soon as three more bytes arrive.
- No timeout: a partial command waits indefinitely for remaining bytes.
- Reset (i_rst=0 at any edge, any state): state -> RX_A, shadow_a, shadow_b, o_dato_a, o_dato_b, o_opcode -> 0, o_valid -> 0. Partial command discarded. Reset dominates i_done_rx in the same cycle.

## Timing
- All outputs registered; reset values all zero, o_valid=0.
- Edge k samples third byte (state RX_OP, i_done_rx=1): from edge k onward new operands/opcode visible; o_valid=1 for the cycle between edge k and k+1; o_valid=0 after edge k+1.
- Minimum command spacing: i_done_rx on three consecutive cycles -> o_valid one cycle after the third; a fourth byte on the VALID cycle is operand A of the next command.
- i_done_rx held high for N cycles = N bytes (no edge detection); receiver must pulse one cycle per byte.
- i_data ignored when i_done_rx=0.

## Test plan
- Reset: drive i_rst=0 two cycles with i_done_rx=1, i_data=0xFF -> all outputs 0, o_valid never 1, state RX_A after release.
- Single command: bytes 0x05, 0x03, 0x20 spaced 10 cycles apart -> outputs stay 0 until third byte; then o_dato_a=0x05, o_dato_b=0x03, o_opcode=0x20, o_valid high exactly one cycle; values held 50 idle cycles.
- Opcode truncation: bytes 0x11, 0x22, 0xE2 -> o_opcode=0x22 (NB_OP=6).
- Back-to-back: i_done_rx high six consecutive cycles with bytes 0x01,0x02,0x20,0x0A,0x0B,0x22 -> o_valid pulses at cycle 4 (outputs 0x01/0x02/0x20) and cycle 7 (0x0A/0x0B/0x22); fourth byte, arriving in VALID, captured as A.
- Outputs stable during assembly: after command 0x05/0x03/0x20, send 0x99, 0x88 only -> outputs remain 0x05/0x03/0x20, o_valid stays 0.
- Reset mid-command: send 0x77 (A), 0x66 (B), assert reset one cycle, then send 0x01, 0x02, 0x24 -> outputs 0x01/0x02/0x24 with one o_valid; 0x77/0x66 never appear.

Source files
------------

// File: rtl/interfaz_rx.sv
// Receive-side command assembler: gathers operand A, operand B and opcode bytes
// from the UART receiver and hands them to the ALU with a one-cycle valid strobe.
module interfaz_rx #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_done_rx,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic               o_valid
);

  typedef enum logic [1:0] {
    RX_A  = 2'd0,
    RX_B  = 2'd1,
    RX_OP = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] shadow_a_q, shadow_a_d;
  logic [NB_DATA-1:0] shadow_b_q, shadow_b_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   opcode_q, opcode_d;

  always_comb begin
    state_d    = state_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    opcode_d   = opcode_q;
    case (state_q)
      RX_A: begin
        if (i_done_rx) begin
          shadow_a_d = i_data;
          state_d    = RX_B;
        end
      end
      RX_B: begin
        if (i_done_rx) begin
          shadow_b_d = i_data;
          state_d    = RX_OP;
        end
      end
      RX_OP: begin
        // All three fields update on the same edge so the ALU never sees a mix.
        if (i_done_rx) begin
          dato_a_d = shadow_a_q;
          dato_b_d = shadow_b_q;
          opcode_d = i_data[NB_OP-1:0];
          state_d  = VALID;
        end
      end
      VALID: begin
        // A byte arriving during the strobe cycle starts the next command.
        if (i_done_rx) begin
          shadow_a_d = i_data;
          state_d    = RX_B;
        end else begin
          state_d    = RX_A;
        end
      end
      default: state_d = RX_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= RX_A;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= '0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      opcode_q   <= opcode_d;
    end
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_opcode = opcode_q;
  assign o_valid  = (state_q == VALID);

endmodule

// File: tb/tb_interfaz_rx.sv
// Directed bench for interfaz_rx: a byte-count model predicts every output each
// cycle, and a few literal expectations pin the model against hand-computed values.
module tb_interfaz_rx;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [NB_DATA-1:0] i_data;
  logic               i_done_rx;
  logic [NB_DATA-1:0] o_dato_a;
  logic [NB_DATA-1:0] o_dato_b;
  logic [NB_OP-1:0]   o_opcode;
  logic               o_valid;

  always #5 i_clk = ~i_clk;

  interfaz_rx #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_done_rx (i_done_rx),
    .o_dato_a  (o_dato_a),
    .o_dato_b  (o_dato_b),
    .o_opcode  (o_opcode),
    .o_valid   (o_valid)
  );

  // Model: a command is every group of three accepted bytes.
  int                 m_cnt;
  logic [NB_DATA-1:0] m_bytes [3];
  logic [NB_DATA-1:0] m_a, m_b;
  logic [NB_OP-1:0]   m_op;
  logic               m_valid;

  int vectors     = 0;
  int miscompares = 0;
  int valid_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of input, advance the model on the edge, then compare.
  task automatic step(input logic rst_n, input logic done, input logic [NB_DATA-1:0] d);
    i_rst     = rst_n;
    i_done_rx = done;
    i_data    = d;
    @(posedge i_clk);
    m_valid = 1'b0;
    if (!rst_n) begin
      m_cnt = 0;
      m_a   = '0;
      m_b   = '0;
      m_op  = '0;
    end else if (done) begin
      m_bytes[m_cnt] = d;
      if (m_cnt == 2) begin
        m_a     = m_bytes[0];
        m_b     = m_bytes[1];
        m_op    = m_bytes[2][NB_OP-1:0];
        m_valid = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 3;
    end
    #1;
    chk("o_dato_a", 32'(o_dato_a), 32'(m_a));
    chk("o_dato_b", 32'(o_dato_b), 32'(m_b));
    chk("o_opcode", 32'(o_opcode), 32'(m_op));
    chk("o_valid",  32'(o_valid),  32'(m_valid));
    if (o_valid === 1'b1) valid_count++;
    $display("t=%0t rst_n=%0b done=%0b data=%02h -> a=%02h b=%02h op=%02h v=%0b",
             $time, rst_n, done, d, o_dato_a, o_dato_b, o_opcode, o_valid);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    step(1'b1, 1'b1, a);
    step(1'b1, 1'b1, b);
    step(1'b1, 1'b1, op);
    idle(1);
  endtask

  initial begin
    m_cnt   = 0;
    m_valid = 1'b0;
    i_rst = 1'b0; i_done_rx = 1'b0; i_data = '0;

    // Reset with the receiver strobing 0xFF: reset must dominate.
    valid_count = 0;
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    idle(3);
    chk("reset_valid_cnt", 32'(valid_count), 32'd0);
    chk("reset_dato_a", 32'(o_dato_a), 32'h00);

    // Single command, bytes spaced 10 cycles apart.
    valid_count = 0;
    step(1'b1, 1'b1, 8'h05); idle(9);
    step(1'b1, 1'b1, 8'h03); idle(9);
    chk("single_pre_a", 32'(o_dato_a), 32'h00);
    step(1'b1, 1'b1, 8'h20);
    chk("single_valid_now", 32'(o_valid), 32'd1);
    idle(50);
    chk("single_a",  32'(o_dato_a), 32'h05);
    chk("single_b",  32'(o_dato_b), 32'h03);
    chk("single_op", 32'(o_opcode), 32'h20);
    chk("single_model_op", 32'(m_op), 32'h20);
    chk("single_valid_cnt", 32'(valid_count), 32'd1);

    // Opcode truncation: 0xE2 keeps only its low six bits.
    send3(8'h11, 8'h22, 8'hE2);
    chk("trunc_op", 32'(o_opcode), 32'h22);
    chk("trunc_model_op", 32'(m_op), 32'h22);

    // Back-to-back: six consecutive bytes, fourth lands in the valid cycle.
    valid_count = 0;
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h20);
    chk("b2b_v1", 32'(o_valid), 32'd1);
    chk("b2b_a1", 32'(o_dato_a), 32'h01);
    step(1'b1, 1'b1, 8'h0A);
    chk("b2b_hold_b1", 32'(o_dato_b), 32'h02);
    step(1'b1, 1'b1, 8'h0B);
    step(1'b1, 1'b1, 8'h22);
    chk("b2b_v2", 32'(o_valid), 32'd1);
    chk("b2b_a2", 32'(o_dato_a), 32'h0A);
    chk("b2b_b2", 32'(o_dato_b), 32'h0B);
    chk("b2b_op2", 32'(o_opcode), 32'h22);
    idle(2);
    chk("b2b_valid_cnt", 32'(valid_count), 32'd2);

    // Outputs stay put while a partial command is assembled.
    send3(8'h05, 8'h03, 8'h20);
    valid_count = 0;
    step(1'b1, 1'b1, 8'h99); idle(3);
    step(1'b1, 1'b1, 8'h88); idle(20);
    chk("stable_a",  32'(o_dato_a), 32'h05);
    chk("stable_b",  32'(o_dato_b), 32'h03);
    chk("stable_op", 32'(o_opcode), 32'h20);
    chk("stable_valid_cnt", 32'(valid_count), 32'd0);

    // Reset mid-command discards the partial bytes.
    step(1'b0, 1'b0, 8'h00);
    idle(1);
    valid_count = 0;
    step(1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h66);
    step(1'b0, 1'b0, 8'h00);
    idle(2);
    send3(8'h01, 8'h02, 8'h24);
    idle(3);
    chk("rstmid_a",  32'(o_dato_a), 32'h01);
    chk("rstmid_b",  32'(o_dato_b), 32'h02);
    chk("rstmid_op", 32'(o_opcode), 32'h24);
    chk("rstmid_valid_cnt", 32'(valid_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
